// File: rtl/tx_pkg.sv
// Shared constants and state type for the DCS transmit interleaver/serializer.
package tx_pkg;

  localparam int unsigned CODED_W = 96;
  localparam int unsigned ROWS    = 8;
  localparam int unsigned COLS    = 12;
  localparam int unsigned SYNC_W  = 16;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 16'hEB90;

  localparam int unsigned CNT_W      = $clog2(CODED_W);
  localparam int unsigned SYNC_IDX_W = $clog2(SYNC_W);

  // Evaluated by the top at elaboration; the matrix must exactly tile the block.
  localparam bit SHAPE_OK = (ROWS * COLS == CODED_W);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } tx_state_e;

endpackage

// File: rtl/tx_block_interleaver.sv
// Combinational 8x12 block interleaver: written row-wise in FEC order, read column-wise.
module tx_block_interleaver
  import tx_pkg::*;
(
  input  logic [CODED_W-1:0] block,
  output logic [CODED_W-1:0] ilv
);

  // ilv[j] is output bit j; FEC order index i lives at block[CODED_W-1-i].
  for (genvar j = 0; j < CODED_W; j++) begin : g_map
    localparam int unsigned I = (j % ROWS) * COLS + (j / ROWS);
    assign ilv[j] = block[CODED_W-1-I];
  end

endmodule

// File: rtl/tx_interleave_serializer.sv
// Latches a coded block, interleaves it and sends sync word + data MSB-first on a bit stream.
module tx_interleave_serializer
  import tx_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [CODED_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx_bit,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sof,
  output logic               tx_eof,
  output logic               frame_done,
  output logic               busy
);

  if (!SHAPE_OK) begin : g_shape_check
    $error("tx_interleave_serializer: ROWS*COLS must equal CODED_W");
  end

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODED_W-1:0] block_q, block_d;
  logic [CODED_W-1:0] ilv;

  logic                  fire_in, fire_tx;
  logic [SYNC_IDX_W-1:0] sync_idx;
  logic in_ready_d, tx_bit_d, tx_valid_d, tx_sof_d, tx_eof_d, frame_done_d, busy_d;

  tx_block_interleaver u_ilv (
    .block (block_q),
    .ilv   (ilv)
  );

  always_comb begin
    // in_ready also gates the cycle right after reset, when state is IDLE but in_ready is 0.
    fire_in      = (state_q == IDLE) && in_ready && in_valid;
    fire_tx      = tx_valid && tx_ready;
    state_d      = state_q;
    cnt_d        = cnt_q;
    block_d      = block_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_in) begin
          state_d = SYNC;
          cnt_d   = '0;
          block_d = in_data;
        end
      end
      SYNC: begin
        if (fire_tx) begin
          if (cnt_q == CNT_W'(SYNC_W - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (fire_tx) begin
          if (cnt_q == CNT_W'(CODED_W - 1)) begin
            state_d      = IDLE;
            cnt_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next state and count.
    sync_idx   = SYNC_IDX_W'(SYNC_W - 1) - cnt_d[SYNC_IDX_W-1:0];
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    tx_valid_d = (state_d != IDLE);
    tx_sof_d   = (state_d == SYNC) && (cnt_d == '0);
    tx_eof_d   = (state_d == DATA) && (cnt_d == CNT_W'(CODED_W - 1));
    case (state_d)
      SYNC:    tx_bit_d = SYNC_WORD[sync_idx];
      DATA:    tx_bit_d = ilv[cnt_d];
      default: tx_bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      block_q    <= '0;
      in_ready   <= 1'b0;
      tx_bit     <= 1'b0;
      tx_valid   <= 1'b0;
      tx_sof     <= 1'b0;
      tx_eof     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      block_q    <= block_d;
      in_ready   <= in_ready_d;
      tx_bit     <= tx_bit_d;
      tx_valid   <= tx_valid_d;
      tx_sof     <= tx_sof_d;
      tx_eof     <= tx_eof_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_tx_interleave_serializer.sv
// Randomized bench for tx_interleave_serializer against a matrix-level interleaver model.
module tb_tx_interleave_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_sof;
  logic        tx_eof;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit stall_en = 1'b0;

  tx_interleave_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_sof     (tx_sof),
    .tx_eof     (tx_eof),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [111:0] bits;
    int           nbits;
    bit           sof_bad;
    bit           eof_bad;
    bit           gap_ok;
    int           stall_bad;
    int           first_cyc;
    int           done_cyc;
  } rec_t;

  rec_t frames[$];
  rec_t cur;
  int   mon_n      = 0;
  int   done_count = 0;
  bit   prev_stall = 1'b0;
  bit   last_final = 1'b0;
  logic [2:0] prev_out = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: FEC-order bits fill an 8x12 matrix by rows, then leave by columns.
  function automatic logic [111:0] model_frame(input logic [95:0] blk);
    bit          fec[96];
    bit          m[8][12];
    logic [95:0] data;
    int          j;
    for (int i = 0; i < 96; i++) fec[i] = blk[95-i];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) m[r][c] = fec[r*12+c];
    j = 0;
    for (int c = 0; c < 12; c++)
      for (int r = 0; r < 8; r++) begin
        data[95-j] = m[r][c];
        j++;
      end
    return {16'hEB90, data};
  endfunction

  // Stream monitor: collects each frame as transmitted and flags protocol problems.
  always @(negedge clk) begin
    if (frame_done) begin
      cur.nbits    = mon_n;
      cur.gap_ok   = last_final;
      cur.done_cyc = cyc;
      frames.push_back(cur);
      done_count++;
    end
    last_final = 1'b0;
    tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!tx_valid) begin
      mon_n         = 0;
      prev_stall    = 1'b0;
      cur.sof_bad   = 1'b0;
      cur.eof_bad   = 1'b0;
      cur.stall_bad = 0;
      cur.bits      = '0;
    end else begin
      if (prev_stall && ({tx_bit, tx_sof, tx_eof} !== prev_out)) cur.stall_bad++;
      if (mon_n == 0 && !prev_stall) cur.first_cyc = cyc;
      if (tx_sof !== (mon_n == 0)) cur.sof_bad = 1'b1;
      if (tx_eof !== (mon_n == 111)) cur.eof_bad = 1'b1;
      if (tx_ready) begin
        if (mon_n < 112) cur.bits[111-mon_n] = tx_bit;
        mon_n++;
        last_final = (mon_n == 112);
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
      end
      prev_out = {tx_bit, tx_sof, tx_eof};
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic send(input logic [95:0] blk, output int acc);
    int k;
    for (k = 0; k < 400; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (k == 400) check("send_timeout", 0, 1);
    in_data  = blk;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    acc      = cyc;
  endtask

  task automatic get_frame(output rec_t r);
    int k = 0;
    while (frames.size() == 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (frames.size() == 0) begin
      check("frame_timeout", 0, 1);
      r = '{default: 0};
    end else begin
      r = frames.pop_front();
    end
  endtask

  task automatic check_frame(input string tag, input logic [95:0] blk, input int acc,
                             input bit timed, output rec_t r);
    get_frame(r);
    check({tag, "_bits"}, r.bits, model_frame(blk));
    check({tag, "_nbits"}, r.nbits, 112);
    check({tag, "_sof"}, r.sof_bad, 0);
    check({tag, "_eof"}, r.eof_bad, 0);
    check({tag, "_stall_hold"}, r.stall_bad, 0);
    check({tag, "_done_after_last"}, r.gap_ok, 1);
    check({tag, "_first_cycle"}, r.first_cyc, acc);
    if (timed) check({tag, "_latency"}, r.done_cyc - r.first_cyc, 112);
  endtask

  initial begin
    rec_t        r, ra, rb;
    int          acc, acc_b, k, dc;
    logic [95:0] blk, blk_b;
    int          one_k[4];
    int          one_j[4];
    one_k = '{95, 94, 0, 83};
    one_j = '{0, 8, 95, 1};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, tx_bit, tx_valid, tx_sof, tx_eof, frame_done, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // All-zero block: sync pattern, zero data, nominal timing.
    send('0, acc);
    check_frame("zero", '0, acc, 1'b1, r);
    check("sync_word", r.bits[111:96], 16'b1110101110010000);
    check("zero_data", r.bits[95:0], 0);

    // Single-bit blocks pin the interleave map at known positions.
    for (int t = 0; t < 4; t++) begin
      blk = '0;
      blk[one_k[t]] = 1'b1;
      send(blk, acc);
      check_frame($sformatf("onehot%0d", one_k[t]), blk, acc, 1'b1, r);
      check($sformatf("onehot%0d_pos", one_k[t]), r.bits[95:0], 96'd1 << (95 - one_j[t]));
    end

    for (int t = 0; t < 4; t++) begin
      blk = {$urandom(), $urandom(), $urandom()};
      send(blk, acc);
      check_frame($sformatf("rand%0d", t), blk, acc, 1'b1, r);
    end

    stall_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      blk = {$urandom(), $urandom(), $urandom()};
      send(blk, acc);
      check_frame($sformatf("stall%0d", t), blk, acc, 1'b0, r);
    end
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    // in_valid held with changing data while busy; the next block lands on frame_done.
    blk   = {$urandom(), $urandom(), $urandom()};
    blk_b = {$urandom(), $urandom(), $urandom()};
    send(blk, acc);
    in_valid = 1'b1;
    in_data  = {$urandom(), $urandom(), $urandom()};
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready) break;
      in_data = {$urandom(), $urandom(), $urandom()};
    end
    check("busy_ready_wait", k < 400, 1);
    check("busy_ready_at_done", frame_done, 1);
    in_data = blk_b;
    @(negedge clk);
    in_valid = 1'b0;
    acc_b    = cyc;
    check_frame("busy_a", blk, acc, 1'b1, ra);
    check_frame("busy_b", blk_b, acc_b, 1'b1, rb);
    check("busy_zero_gap", rb.first_cyc, ra.done_cyc + 1);

    // Abort mid-data with a synchronous reset.
    blk = {$urandom(), $urandom(), $urandom()};
    send(blk, acc);
    dc = done_count;
    for (k = 0; k < 400; k++) begin
      if (mon_n >= 56 && tx_valid) break;
      @(negedge clk);
    end
    check("abort_reach_bit40", k < 400, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {in_ready, tx_bit, tx_valid, tx_sof, tx_eof, frame_done, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", in_ready, 1);
    @(negedge clk);
    check("abort_no_done", done_count - dc, 0);
    check("abort_no_frame", frames.size(), 0);

    blk = {$urandom(), $urandom(), $urandom()};
    send(blk, acc);
    check_frame("after_abort", blk, acc, 1'b1, r);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
